// File: rtl/alu_pkg.sv
// Shared types and encodings for the RV32I ALU decode/issue stage.
// Holds the ALU op enum, opcode/funct constants and the decoded-entry struct.
package alu_pkg;

    localparam int ALU_XLEN       = 32;
    localparam int ALU_SEL_SIZE   = 4;
    localparam int ALU_SHIFT_SIZE = 5;

    typedef enum logic [ALU_SEL_SIZE-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLT   = 4'd2,
        ALU_SLTU  = 4'd3,
        ALU_AND   = 4'd4,
        ALU_OR    = 4'd5,
        ALU_XOR   = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef struct packed {
        logic                      alu_enable;
        alu_op_e                   sel;
        logic [ALU_SHIFT_SIZE-1:0] shift_amt;
        logic [ALU_XLEN-1:0]       a;
        logic [ALU_XLEN-1:0]       b;
        logic [4:0]                rd;
        logic                      rd_we;
        logic                      illegal;
    } alu_entry_t;

    // The ALU only compares unsigned; flipping the sign bit of both operands
    // turns that into a signed comparison.
    function automatic logic [ALU_XLEN-1:0] slt_bias(input logic [ALU_XLEN-1:0] x);
        return x ^ {1'b1, {(ALU_XLEN-1){1'b0}}};
    endfunction

endpackage

// File: rtl/alu_instr_decoder.sv
// Combinational RV32I ALU-instruction decoder: instruction, PC and register
// operands in, one decoded issue entry out.
module alu_instr_decoder
    import alu_pkg::*;
(
    input  logic [31:0]         instr,
    input  logic [ALU_XLEN-1:0] pc,
    input  logic [ALU_XLEN-1:0] rs1_data,
    input  logic [ALU_XLEN-1:0] rs2_data,
    output alu_entry_t          entry
);

    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic [4:0]                rd;
    logic [ALU_XLEN-1:0]       imm_i;
    logic [ALU_XLEN-1:0]       upper;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd     = instr[11:7];
    assign imm_i  = {{(ALU_XLEN-12){instr[31]}}, instr[31:20]};
    assign upper  = {{(ALU_XLEN-20){1'b0}}, instr[31:12]};

    logic                      legal;
    alu_op_e                   op;
    logic [ALU_XLEN-1:0]       opa;
    logic [ALU_XLEN-1:0]       opb;
    logic [ALU_SHIFT_SIZE-1:0] shamt;

    always_comb begin
        legal = 1'b0;
        op    = ALU_ADD;
        opa   = rs1_data;
        opb   = rs2_data;
        shamt = '0;

        case (opcode)
            OPC_OP_IMM: begin
                legal = 1'b1;
                opb   = imm_i;
                case (funct3)
                    F3_ADD:  op = ALU_ADD;
                    F3_SLT: begin
                        op  = ALU_SLT;
                        opa = slt_bias(rs1_data);
                        opb = slt_bias(imm_i);
                    end
                    F3_SLTU: op = ALU_SLTU;
                    F3_XOR:  op = ALU_XOR;
                    F3_OR:   op = ALU_OR;
                    F3_SLL: begin
                        op    = ALU_SLL;
                        shamt = instr[24:20];
                        legal = (funct7 == F7_BASE);
                    end
                    F3_SR: begin
                        shamt = instr[24:20];
                        if (funct7 == F7_BASE) begin
                            op = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            op = ALU_SRA;
                        end else begin
                            legal = 1'b0;
                        end
                    end
                    default: op = ALU_AND;
                endcase
            end
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                    case (funct3)
                        F3_ADD:  op = ALU_ADD;
                        F3_SLL: begin
                            op    = ALU_SLL;
                            shamt = rs2_data[ALU_SHIFT_SIZE-1:0];
                        end
                        F3_SLT: begin
                            op  = ALU_SLT;
                            opa = slt_bias(rs1_data);
                            opb = slt_bias(rs2_data);
                        end
                        F3_SLTU: op = ALU_SLTU;
                        F3_XOR:  op = ALU_XOR;
                        F3_SR: begin
                            op    = ALU_SRL;
                            shamt = rs2_data[ALU_SHIFT_SIZE-1:0];
                        end
                        F3_OR:   op = ALU_OR;
                        default: op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    // The ALU computes b - a, so the operands swap for SUB.
                    legal = 1'b1;
                    op    = ALU_SUB;
                    opa   = rs2_data;
                    opb   = rs1_data;
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    legal = 1'b1;
                    op    = ALU_SRA;
                    shamt = rs2_data[ALU_SHIFT_SIZE-1:0];
                end
            end
            OPC_LUI: begin
                legal = 1'b1;
                op    = ALU_LUI;
                opa   = upper;
                opb   = '0;
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                op    = ALU_AUIPC;
                opa   = upper;
                opb   = pc;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        entry    = '0;
        entry.rd = rd;
        if (legal) begin
            entry.alu_enable = 1'b1;
            entry.sel        = op;
            entry.shift_amt  = shamt;
            entry.a          = opa;
            entry.b          = opb;
            entry.rd_we      = (rd != 5'd0);
        end else begin
            entry.illegal    = 1'b1;
        end
    end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I ALU decode/issue stage: decodes each accepted instruction and queues it
// in a 2-entry buffer (head + skid slot) in front of the ALU.
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int XLEN       = ALU_XLEN,
    parameter int SEL_SIZE   = ALU_SEL_SIZE,
    parameter int SHIFT_SIZE = ALU_SHIFT_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [XLEN-1:0]       in_rs1_data,
    input  logic [XLEN-1:0]       in_rs2_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_alu_enable,
    output logic [SEL_SIZE-1:0]   out_alu_sel,
    output logic [SHIFT_SIZE-1:0] out_shift_amt,
    output logic [XLEN-1:0]       out_data_a,
    output logic [XLEN-1:0]       out_data_b,
    output logic [4:0]            out_rd,
    output logic                  out_rd_we,
    output logic                  out_illegal
);

    // Handshake: a beat moves on either side only in a cycle where valid and
    // ready are both high at the rising edge; out_* fields are held steady while
    // out_valid is high and out_ready is low. in_ready depends on stored count
    // only, so there is no combinational path from out_ready to in_ready.

    alu_entry_t dec_entry;

    alu_instr_decoder u_decoder (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .entry    (dec_entry)
    );

    alu_entry_t head_q, head_d;
    alu_entry_t skid_q, skid_d;
    logic [1:0] count_q, count_d;
    logic       push;
    logic       pop;

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head always drives the outputs; unused slots are kept zero so an empty
    // stage presents all-zero fields.
    always_comb begin
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;

        if (flush) begin
            head_d  = '0;
            skid_d  = '0;
            count_d = 2'd0;
        end else begin
            if (pop) begin
                head_d  = (count_q == 2'd2) ? skid_q : '0;
                skid_d  = '0;
                count_d = count_q - 2'd1;
            end
            if (push) begin
                if (count_d == 2'd0) begin
                    head_d = dec_entry;
                end else begin
                    skid_d = dec_entry;
                end
                count_d = count_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            skid_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end

    assign out_alu_enable = head_q.alu_enable;
    assign out_alu_sel    = head_q.sel;
    assign out_shift_amt  = head_q.shift_amt;
    assign out_data_a     = head_q.a;
    assign out_data_b     = head_q.b;
    assign out_rd         = head_q.rd;
    assign out_rd_we      = head_q.rd_we;
    assign out_illegal    = head_q.illegal;

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Pipelined RV32I integer decode/issue stage for the ALU.
- Takes fetched instruction, PC and register-file read data.
- Produces registered ALU controls (enable, sel, shift_amt, operand A/B) plus writeback tag (rd, we), over valid/ready handshakes on both sides.
- Sits between regfile read and the combinational ALU; absorbs ALU-side backpressure with a 2-entry skid buffer.

Parameters:
- XLEN, 32, datapath width
- SEL_SIZE, 4, ALU select width
- SHIFT_SIZE, 5, shift amount width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; drop all buffered entries
- in_valid  in  1  input entry valid
- in_ready  out  1  stage can accept an entry
- in_instr  in  32  RV32I instruction word
- in_pc  in  XLEN  PC of in_instr
- in_rs1_data  in  XLEN  rs1 read value
- in_rs2_data  in  XLEN  rs2 read value
- out_valid  out  1  issued entry valid
- out_ready  in  1  ALU/writeback consumes entry
- out_alu_enable  out  1  ALU enable
- out_alu_sel  out  SEL_SIZE  ALU operation code
- out_shift_amt  out  SHIFT_SIZE  shift amount
- out_data_a  out  XLEN  ALU operand A
- out_data_b  out  XLEN  ALU operand B
- out_rd  out  5  destination register
- out_rd_we  out  1  register write enable
- out_illegal  out  1  unsupported or illegal encoding

Behaviour:
- ALU op encoding (fixed): ADD=0, SUB=1, SLT=2, SLTU=3, AND=4, OR=5, XOR=6, SLL=7, SRL=8, SRA=9, LUI=10, AUIPC=11.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Output fields stable while out_valid && !out_ready.
- Latency: 1 cycle, input accept to out_valid, when the buffer is empty.
- Storage:
  - 2-entry FIFO: head drives outputs; second entry is the skid slot.
  - in_ready = (count < 2), registered-equivalent; no combinational path from out_ready to in_ready.
  - Simultaneous push and pop at count 1 or 2 keeps count; order preserved.
- Decode (opcode in_instr[6:0]):
  - OP-IMM 0010011: a=rs1, b=sext(I-imm). funct3 maps to ADD/SLT/SLTU/XOR/OR/AND. Shift amount = instr[24:20].
    - SLLI requires funct7=0x00.
    - SRLI/SRAI require funct7 0x00/0x20.
  - OP 0110011, funct7 0x00: a=rs1, b=rs2. Shift amount = rs2[4:0].
  - OP 0110011, funct7 0x20 valid only for SUB/SRA.
  - SUB: ALU computes b−a, so a=rs2, b=rs1.
  - SLT/SLTI: ALU compares unsigned, so bit 31 of both a and b is inverted to give a signed result.
  - LUI 0110111: a={12'b0, instr[31:12]}, b=0.
  - AUIPC 0010111: a={12'b0, instr[31:12]}, b=in_pc.
  - Non-shift ops: shift_amt=0.
- Writeback tag:
  - rd = instr[11:7]; rd_we=1 for legal ops with rd≠0.
  - rd=0: alu_enable still 1, rd_we=0.
- Illegal encoding (any other opcode/funct combination):
  - Entry still issued, in order.
  - illegal=1, alu_enable=0, rd_we=0, sel=0, a=b=0, shift_amt=0.
- Reset (async): count=0, out_valid=0. All output fields 0 (sel=ADD encoding 0). in_ready=1 the first cycle after deassert.
- Reset mid-operation: buffered entries lost, no partial output.
- flush:
  - Next cycle count=0, out_valid=0.
  - An input presented in the flush cycle is discarded.
  - Flush overrides a simultaneous push/pop.
- Full (count=2): in_ready=0; in_valid ignored.
- Empty: out_valid=0; fields hold zero.

Decomposition:
- Package alu_pkg: alu_op_e enum (values above), opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC), funct3/funct7 constants, decoded-entry struct {alu_enable, sel, shift_amt, a, b, rd, rd_we, illegal}.
- Sub-module alu_instr_decoder: purely combinational instr+pc+rs data → entry struct.
- Top instantiates alu_instr_decoder and holds the 2-entry buffer plus handshake.

Test Plan:
- ADDI x5,x1,-1 (0xFFF08293), rs1=5, out_ready=1 → next cycle out_valid=1, sel=ADD, a=0x5, b=0xFFFFFFFF, rd=5, rd_we=1, illegal=0.
- SUB x3,x1,x2 (0x402081B3), rs1=10, rs2=3 → sel=SUB, a=3, b=10. SRAI x4,x4,3 (0x40325213) → sel=SRA, shift_amt=3.
- SLT x6,x1,x2 (0x0020A333), rs1=0xFFFFFFFF, rs2=1 → sel=SLT, a=0x7FFFFFFF, b=0x80000001. LUI x7,0x12345 (0x123453B7) → sel=LUI, a=0x00012345, b=0. AUIPC x8,1 (0x00001417), pc=0x100 → sel=AUIPC, a=1, b=0x100.
- Backpressure: out_ready=0, in_valid=1 for 3 cycles with instrs I0,I1,I2 → in_ready drops after 2 accepts; I2 held by source; out_ready=1 → I0,I1,I2 emitted in order, no loss or duplicate.
- Illegal 0x00000000 and ADD with funct7=0x01 → out_illegal=1, alu_enable=0, rd_we=0; ADDI x0,x0,0 → rd_we=0, alu_enable=1.
- rst_n low with 2 entries buffered → out_valid=0 and all fields 0 immediately (async); flush with count=2 and in_valid=1 → next cycle out_valid=0, count=0.
